// File: rtl/qr_sched_pkg.sv
// Shared types and constants for the 4x4 QR triangularization scheduler:
// scheme selects, FSM states, the fixed Givens step table and tag layout.
package qr_sched_pkg;

  typedef logic [1:0] lane_t;
  typedef logic [2:0] step_idx_t;

  typedef struct packed {
    lane_t row_a;
    lane_t row_b;
    lane_t col;
  } step_t;

  typedef struct packed {
    logic  valid;
    lane_t row_a;
    lane_t row_b;
    lane_t col;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // PE0 vectors pair0 and rotates pair1; PE1 rotates both pairs by PE0's angle.
  localparam logic [1:0] SCHEME_VEC_ROT = 2'd2;
  localparam logic [1:0] SCHEME_ROT     = 2'd2;

  localparam int unsigned NUM_STEPS   = 6;
  localparam step_idx_t   STEPS_DONE  = 3'd6;

  localparam step_t STEP_TABLE [NUM_STEPS] = '{
    '{row_a: 2'd2, row_b: 2'd3, col: 2'd0},
    '{row_a: 2'd1, row_b: 2'd2, col: 2'd0},
    '{row_a: 2'd0, row_b: 2'd1, col: 2'd0},
    '{row_a: 2'd2, row_b: 2'd3, col: 2'd1},
    '{row_a: 2'd1, row_b: 2'd2, col: 2'd1},
    '{row_a: 2'd2, row_b: 2'd3, col: 2'd2}
  };

  // Columns c..3 are rewritten by a step with base column c.
  function automatic logic [3:0] col_mask(input lane_t c);
    return 4'b1111 << c;
  endfunction

endpackage

// File: rtl/qr_sched_pipe.sv
// In-flight step tracker: a DEPTH-stage tag shift pipe whose last stage is
// the writeback slot, plus the OR of all rows currently held by a step.
module qr_sched_pipe
  import qr_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  step_t      push_step,
  output tag_t       wb_tag,
  output logic [3:0] busy_rows,
  output logic       last_wb
);

  tag_t pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      if (push) begin
        pipe[0] <= '{valid: 1'b1, row_a: push_step.row_a,
                     row_b: push_step.row_b, col: push_step.col};
      end else begin
        pipe[0] <= '0;
      end
      for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign wb_tag = pipe[DEPTH-1];

  // A row stays busy through its writeback cycle, so the last stage counts too.
  always_comb begin
    busy_rows = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pipe[i].valid) begin
        busy_rows[pipe[i].row_a] = 1'b1;
        busy_rows[pipe[i].row_b] = 1'b1;
      end
    end
  end

  always_comb begin
    last_wb = pipe[DEPTH-1].valid;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      if (pipe[i].valid) last_wb = 1'b0;
    end
  end

endmodule

// File: rtl/qr_scheduler.sv
// Issue/writeback sequencer for one 4x4 Givens triangularization run; holds
// each step until both of its rows are free of in-flight work.
module qr_scheduler
  import qr_sched_pkg::*;
#(
  parameter int unsigned PE_LAT   = 4,
  parameter int unsigned BITWIDTH = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output logic [1:0] rd_row_a_o,
  output logic [1:0] rd_row_b_o,
  output logic [1:0] rd_col_o,
  output logic [1:0] pe0_valid_o,
  output logic [1:0] pe1_valid_o,
  output logic [1:0] pe0_scheme_o,
  output logic [1:0] pe1_scheme_o,
  output logic       wr_en_o,
  output logic [1:0] wr_row_a_o,
  output logic [1:0] wr_row_b_o,
  output logic [1:0] wr_col_o,
  output logic [3:0] wr_col_mask_o,
  output logic [2:0] step_o
);

  if (PE_LAT < 1 || BITWIDTH < 1) begin : g_param_check
    $error("qr_scheduler: PE_LAT and BITWIDTH must be at least 1");
  end

  state_e     state, state_next;
  step_idx_t  step_cnt;
  step_t      cur;
  logic       issue;
  tag_t       wb_tag;
  logic [3:0] busy_rows;
  logic       last_wb;

  qr_sched_pipe #(.DEPTH(PE_LAT)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_step (cur),
    .wb_tag    (wb_tag),
    .busy_rows (busy_rows),
    .last_wb   (last_wb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (step_cnt == STEPS_DONE && last_wb) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cleared while in DONE so the counter already reads 0 on return to IDLE.
  always_ff @(posedge clk) begin
    if (rst || state == DONE) step_cnt <= '0;
    else if (issue)           step_cnt <= step_cnt + 3'd1;
  end

  always_comb begin
    cur = '0;
    if (step_cnt != STEPS_DONE) cur = STEP_TABLE[step_cnt];
  end

  always_comb begin
    issue = (state == RUN) && (step_cnt != STEPS_DONE) &&
            !busy_rows[cur.row_a] && !busy_rows[cur.row_b];

    busy_o        = (state == RUN);
    done_o        = (state == DONE);
    step_o        = step_cnt;
    rd_en_o       = 1'b0;
    rd_row_a_o    = '0;
    rd_row_b_o    = '0;
    rd_col_o      = '0;
    pe0_valid_o   = '0;
    pe1_valid_o   = '0;
    pe0_scheme_o  = '0;
    pe1_scheme_o  = '0;
    wr_en_o       = 1'b0;
    wr_row_a_o    = '0;
    wr_row_b_o    = '0;
    wr_col_o      = '0;
    wr_col_mask_o = '0;

    if (issue) begin
      rd_en_o      = 1'b1;
      rd_row_a_o   = cur.row_a;
      rd_row_b_o   = cur.row_b;
      rd_col_o     = cur.col;
      pe0_valid_o  = '1;
      pe1_valid_o  = '1;
      pe0_scheme_o = SCHEME_VEC_ROT;
      pe1_scheme_o = SCHEME_ROT;
    end

    if (wb_tag.valid) begin
      wr_en_o       = 1'b1;
      wr_row_a_o    = wb_tag.row_a;
      wr_row_b_o    = wb_tag.row_b;
      wr_col_o      = wb_tag.col;
      wr_col_mask_o = col_mask(wb_tag.col);
    end
  end

endmodule

// File: tb/tb_qr_scheduler.sv
// Scoreboard bench for qr_scheduler: two instances (PE_LAT=4 and PE_LAT=1)
// driven by directed and random start/reset, checked against a step-rule model.
module tb_qr_scheduler;

  typedef struct {
    int cyc;
    int ra;
    int rb;
    int col;
    int mask;
    int stp;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start [2];
  logic       rst   [2];
  logic       busy  [2];
  logic       done  [2];
  logic       rd_en [2];
  logic       wr_en [2];
  logic [1:0] rd_ra [2];
  logic [1:0] rd_rb [2];
  logic [1:0] rd_col[2];
  logic [1:0] pe0v  [2];
  logic [1:0] pe1v  [2];
  logic [1:0] pe0s  [2];
  logic [1:0] pe1s  [2];
  logic [1:0] wr_ra [2];
  logic [1:0] wr_rb [2];
  logic [1:0] wr_col[2];
  logic [3:0] wmask [2];
  logic [2:0] step  [2];

  qr_scheduler #(.PE_LAT(4), .BITWIDTH(18)) dut0 (
    .clk(clk), .rst(rst[0]), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .rd_en_o(rd_en[0]), .rd_row_a_o(rd_ra[0]), .rd_row_b_o(rd_rb[0]), .rd_col_o(rd_col[0]),
    .pe0_valid_o(pe0v[0]), .pe1_valid_o(pe1v[0]), .pe0_scheme_o(pe0s[0]), .pe1_scheme_o(pe1s[0]),
    .wr_en_o(wr_en[0]), .wr_row_a_o(wr_ra[0]), .wr_row_b_o(wr_rb[0]), .wr_col_o(wr_col[0]),
    .wr_col_mask_o(wmask[0]), .step_o(step[0])
  );

  qr_scheduler #(.PE_LAT(1), .BITWIDTH(18)) dut1 (
    .clk(clk), .rst(rst[1]), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .rd_en_o(rd_en[1]), .rd_row_a_o(rd_ra[1]), .rd_row_b_o(rd_rb[1]), .rd_col_o(rd_col[1]),
    .pe0_valid_o(pe0v[1]), .pe1_valid_o(pe1v[1]), .pe0_scheme_o(pe0s[1]), .pe1_scheme_o(pe1s[1]),
    .wr_en_o(wr_en[1]), .wr_row_a_o(wr_ra[1]), .wr_row_b_o(wr_rb[1]), .wr_col_o(wr_col[1]),
    .wr_col_mask_o(wmask[1]), .step_o(step[1])
  );

  int LAT   [2] = '{4, 1};
  int ROW_A [6] = '{2, 1, 0, 2, 1, 2};
  int ROW_B [6] = '{3, 2, 1, 3, 2, 3};
  int COL   [6] = '{0, 0, 0, 1, 1, 2};

  ev_t iss_q[2][$];
  ev_t wb_q [2][$];
  int  bs[2]        = '{1, 1};
  int  be[2]        = '{0, 0};
  int  dn[2]        = '{-1, -1};
  int  idle_from[2] = '{0, 0};
  logic [3:0] row_held[2];

  int obs_iss[$];
  int obs_wb[$];
  int obs_mask[$];
  int obs_done[$];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  t0;

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Reference: steps go in table order, one per cycle at most, each waiting
  // until both rows are past the writeback of the last step that used them.
  task automatic schedule_run(input int d, input int start_cyc, output int last);
    int  free_at[4];
    int  t;
    ev_t ev;
    for (int r = 0; r < 4; r++) free_at[r] = 0;
    t = start_cyc + 1;
    last = t;
    for (int s = 0; s < 6; s++) begin
      if (free_at[ROW_A[s]] > t) t = free_at[ROW_A[s]];
      if (free_at[ROW_B[s]] > t) t = free_at[ROW_B[s]];
      ev.cyc  = t;
      ev.ra   = ROW_A[s];
      ev.rb   = ROW_B[s];
      ev.col  = COL[s];
      ev.mask = (15 << COL[s]) & 15;
      ev.stp  = s;
      iss_q[d].push_back(ev);
      ev.cyc = t + LAT[d];
      wb_q[d].push_back(ev);
      free_at[ROW_A[s]] = t + LAT[d] + 1;
      free_at[ROW_B[s]] = t + LAT[d] + 1;
      last = t + LAT[d];
      t++;
    end
  endtask

  task automatic tick(input bit s0, input bit s1, input bit r0, input bit r1);
    bit sv[2];
    bit rv[2];
    int now;
    int last;
    @(posedge clk);
    #1;
    sv[0] = s0; sv[1] = s1; rv[0] = r0; rv[1] = r1;
    start[0] = s0; start[1] = s1; rst[0] = r0; rst[1] = r1;
    now = cyc;
    for (int d = 0; d < 2; d++) begin
      if (rv[d]) begin
        while (iss_q[d].size() > 0 && iss_q[d][iss_q[d].size()-1].cyc > now)
          void'(iss_q[d].pop_back());
        while (wb_q[d].size() > 0 && wb_q[d][wb_q[d].size()-1].cyc > now)
          void'(wb_q[d].pop_back());
        if (be[d] > now) be[d] = now;
        if (dn[d] > now) dn[d] = -1;
        idle_from[d] = now + 1;
      end else if (sv[d] && now >= idle_from[d]) begin
        schedule_run(d, now, last);
        bs[d] = now + 1;
        be[d] = last;
        dn[d] = last + 1;
        idle_from[d] = last + 2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        int  c;
        bit  eb;
        bit  ed;
        ev_t ev;
        c  = cyc;
        eb = (c >= bs[d] && c <= be[d]);
        ed = (c == dn[d]);
        chk("busy", d, int'(busy[d]), int'(eb));
        chk("done", d, int'(done[d]), int'(ed));
        if (d == 0 && done[d]) obs_done.push_back(c);
        if (!eb && !ed) chk("step_idle", d, int'(step[d]), 0);

        while (iss_q[d].size() > 0 && iss_q[d][0].cyc < c) begin
          ev = iss_q[d].pop_front();
          chk("issue_missed", d, c, ev.cyc);
        end
        while (wb_q[d].size() > 0 && wb_q[d][0].cyc < c) begin
          ev = wb_q[d].pop_front();
          chk("wb_missed", d, c, ev.cyc);
        end

        if (rd_en[d]) begin
          chk("row_hazard", d,
              int'(row_held[d][rd_ra[d]] | row_held[d][rd_rb[d]]), 0);
          row_held[d][rd_ra[d]] = 1'b1;
          row_held[d][rd_rb[d]] = 1'b1;
          if (d == 0) obs_iss.push_back(c);
          if (iss_q[d].size() == 0) begin
            chk("issue_unexpected", d, 1, 0);
          end else begin
            ev = iss_q[d].pop_front();
            chk("issue_cycle", d, c, ev.cyc);
            chk("issue_row_a", d, int'(rd_ra[d]), ev.ra);
            chk("issue_row_b", d, int'(rd_rb[d]), ev.rb);
            chk("issue_col", d, int'(rd_col[d]), ev.col);
            chk("issue_step", d, int'(step[d]), ev.stp);
            chk("issue_valids", d, int'({pe0v[d], pe1v[d]}), 15);
            chk("issue_schemes", d, int'({pe0s[d], pe1s[d]}), 10);
          end
        end else begin
          chk("rd_idle_fields", d,
              int'({rd_ra[d], rd_rb[d], rd_col[d], pe0v[d], pe1v[d], pe0s[d], pe1s[d]}), 0);
        end

        if (wr_en[d]) begin
          row_held[d][wr_ra[d]] = 1'b0;
          row_held[d][wr_rb[d]] = 1'b0;
          if (d == 0) begin
            obs_wb.push_back(c);
            obs_mask.push_back(int'(wmask[d]));
          end
          if (wb_q[d].size() == 0) begin
            chk("wb_unexpected", d, 1, 0);
          end else begin
            ev = wb_q[d].pop_front();
            chk("wb_cycle", d, c, ev.cyc);
            chk("wb_row_a", d, int'(wr_ra[d]), ev.ra);
            chk("wb_row_b", d, int'(wr_rb[d]), ev.rb);
            chk("wb_col", d, int'(wr_col[d]), ev.col);
            chk("wb_mask", d, int'(wmask[d]), ev.mask);
          end
        end else begin
          chk("wr_idle_fields", d, int'({wr_ra[d], wr_rb[d], wr_col[d], wmask[d]}), 0);
        end

        if (rst[d]) row_held[d] = '0;
      end
    end
  end

  task automatic clear_obs();
    obs_iss.delete();
    obs_wb.delete();
    obs_mask.delete();
    obs_done.delete();
  endtask

  // Absolute PE_LAT=4 timeline of a lone run, relative to the start cycle.
  task automatic check_timing(input int ts);
    int iss_ref[6];
    int wb_ref[6];
    int mask_ref[6];
    iss_ref  = '{1, 6, 11, 12, 17, 22};
    wb_ref   = '{5, 10, 15, 16, 21, 26};
    mask_ref = '{15, 15, 15, 14, 14, 12};
    chk("run_issue_count", 0, obs_iss.size(), 6);
    chk("run_wb_count", 0, obs_wb.size(), 6);
    chk("run_done_count", 0, obs_done.size(), 1);
    if (obs_iss.size() == 6 && obs_wb.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("timeline_issue", 0, obs_iss[i] - ts, iss_ref[i]);
        chk("timeline_wb", 0, obs_wb[i] - ts, wb_ref[i]);
        chk("timeline_mask", 0, obs_mask[i], mask_ref[i]);
      end
    end
    if (obs_done.size() == 1) chk("timeline_done", 0, obs_done[0] - ts, 27);
  endtask

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    rst[0]   = 1'b1; rst[1]   = 1'b1;
    row_held[0] = '0; row_held[1] = '0;
    tick(0, 0, 1, 1);
    mon_en = 1'b1;
    tick(0, 0, 1, 1);
    repeat (3) tick(0, 0, 0, 0);

    // Lone run on both instances.
    clear_obs();
    tick(1, 1, 0, 0);
    t0 = cyc;
    repeat (35) tick(0, 0, 0, 0);
    check_timing(t0);

    // start held through RUN and DONE: one run on dut0, back-to-back on dut1.
    clear_obs();
    tick(1, 1, 0, 0);
    repeat (27) tick(1, 1, 0, 0);
    repeat (40) tick(0, 0, 0, 0);
    chk("held_start_runs", 0, obs_done.size(), 1);

    // Reset eight cycles into a run, then a fresh run.
    clear_obs();
    tick(1, 1, 0, 0);
    repeat (7) tick(0, 0, 0, 0);
    tick(0, 0, 1, 1);
    repeat (30) tick(0, 0, 0, 0);
    chk("abort_issues", 0, obs_iss.size(), 2);
    chk("abort_wbs", 0, obs_wb.size(), 1);
    chk("abort_done", 0, obs_done.size(), 0);
    clear_obs();
    tick(1, 1, 0, 0);
    t0 = cyc;
    repeat (35) tick(0, 0, 0, 0);
    check_timing(t0);

    // Random starts and occasional resets.
    repeat (2500) tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
    repeat (40) tick(0, 0, 0, 0);

    for (int d = 0; d < 2; d++) begin
      chk("issue_left", d, iss_q[d].size(), 0);
      chk("wb_left", d, wb_q[d].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
